mux_rr_lanes: RTL and testbench

Parametrised N:1 round-robin lane serializer for the PHY transmit path. It takes LANES parallel byte lanes in the slow domain and time-multiplexes them onto one output stream clocked at LANES× the lane rate. Inputs are captured into a per-frame snapshot register bank, and lanes can be masked. An align input restarts the frame phase, and the output register holds its last word on idle slots. It replaces the fixed 2-lane alternating mux stages in the multiplexer tree.

---
 rtl/mux_rr_lanes_if.sv | 60 ++++++
 rtl/mux_rr_lanes.sv | 123 ++++++++++++
 tb/tb_mux_rr_lanes.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_lanes_if.sv
// ---------------------------------------------------------------------------
// mux_rr_lanes_if
//   Bundles the lane-side inputs and the serialized output stream of the
//   round-robin lane serializer. Clock and reset stay outside the interface.
//
//   Parameters
//     WIDTH  data bits per lane
//     LANES  number of parallel input lanes
//
//   Signals
//     data_in      LANES*WIDTH  lane k on bits [k*WIDTH +: WIDTH]
//     valid_in     LANES        per-lane valid
//     lane_en      LANES        per-lane enable mask
//     align        1            frame-phase restart
//     data_out     WIDTH        serialized data, holds on idle slots
//     valid_out    1            data_out carries a new word this cycle
//     lane_out     SEL_W        lane index of the current output slot
//     frame_start  1            high on the slot carrying lane 0
//
//   Modports
//     master  drives the lane inputs, observes the serialized stream
//     slave   the serializer itself
// ---------------------------------------------------------------------------
interface mux_rr_lanes_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) ();
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*WIDTH-1:0] data_in;
    logic [LANES-1:0]       valid_in;
    logic [LANES-1:0]       lane_en;
    logic                   align;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic [SEL_W-1:0]       lane_out;
    logic                   frame_start;

    modport master (
        output data_in,
        output valid_in,
        output lane_en,
        output align,
        input  data_out,
        input  valid_out,
        input  lane_out,
        input  frame_start
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  lane_en,
        input  align,
        output data_out,
        output valid_out,
        output lane_out,
        output frame_start
    );
endinterface

// File: rtl/mux_rr_lanes.sv
// ---------------------------------------------------------------------------
// mux_rr_lanes
//   N:1 round-robin lane serializer for the PHY transmit path. LANES parallel
//   lanes are captured once per frame into a snapshot bank and emitted one
//   lane per clk_nf cycle. Disabled or invalid lanes produce idle slots on
//   which data_out holds its previous word. align restarts the frame phase.
//
//   Ports
//     clk_nf   input  fast clock, LANES x the lane rate
//     reset_L  input  asynchronous active-low reset
//     bus      mux_rr_lanes_if.slave (lane inputs and serialized output)
// ---------------------------------------------------------------------------
module mux_rr_lanes #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic          clk_nf,
    input  logic          reset_L,
    mux_rr_lanes_if.slave bus
);
    localparam int               SEL_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [SEL_W-1:0] SEL_ZERO = '0;
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(LANES - 1);

    // Slot counter
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    // Per-frame snapshot bank
    logic [WIDTH-1:0] snap_data_q [LANES];
    logic [WIDTH-1:0] snap_data_d [LANES];
    logic [LANES-1:0] snap_valid_q;
    logic [LANES-1:0] snap_valid_d;

    // Output register stage
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             valid_out_q;
    logic             valid_out_d;
    logic [SEL_W-1:0] lane_out_q;
    logic [SEL_W-1:0] lane_out_d;
    logic             frame_start_q;
    logic             frame_start_d;

    logic             last_slot;
    logic             snap_load;

    assign last_slot = (sel_q == SEL_LAST);
    // The bank reloads on the last slot of each frame so the next frame's
    // lane 0 is ready on the following edge; align forces an early reload.
    assign snap_load = last_slot || bus.align;

    // Slot counter next state: wraps after the last lane, align restarts it.
    always_comb begin
        sel_d = sel_q + SEL_ONE;
        if (bus.align || last_slot) begin
            sel_d = SEL_ZERO;
        end
    end

    // Snapshot bank next state. Masked lanes are stored as invalid, so later
    // changes to lane_en/valid_in only matter at the next load.
    always_comb begin
        snap_valid_d = snap_valid_q;
        for (int k = 0; k < LANES; k++) begin
            snap_data_d[k] = snap_data_q[k];
        end
        if (snap_load) begin
            snap_valid_d = bus.valid_in & bus.lane_en;
            for (int k = 0; k < LANES; k++) begin
                snap_data_d[k] = bus.data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage next state. It reads the pre-edge snapshot, so on the wrap
    // edge it still emits the old frame's last lane while the bank reloads.
    always_comb begin
        data_out_d    = data_out_q;
        valid_out_d   = 1'b0;
        lane_out_d    = sel_q;
        frame_start_d = (sel_q == SEL_ZERO);
        if (bus.align) begin
            // Flush slot: nothing is emitted while the phase restarts.
            lane_out_d    = SEL_ZERO;
            frame_start_d = 1'b0;
        end else if (snap_valid_q[sel_q]) begin
            data_out_d  = snap_data_q[sel_q];
            valid_out_d = 1'b1;
        end
    end

    // Register stage: counter, snapshot bank and output stage
    always_ff @(posedge clk_nf or negedge reset_L) begin
        if (!reset_L) begin
            sel_q         <= SEL_ZERO;
            snap_valid_q  <= '0;
            for (int k = 0; k < LANES; k++) begin
                snap_data_q[k] <= '0;
            end
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            lane_out_q    <= SEL_ZERO;
            frame_start_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            snap_valid_q  <= snap_valid_d;
            for (int k = 0; k < LANES; k++) begin
                snap_data_q[k] <= snap_data_d[k];
            end
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            lane_out_q    <= lane_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.lane_out    = lane_out_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_mux_rr_lanes.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_lanes
//   Directed bench for mux_rr_lanes: a WIDTH=8/LANES=4 instance and a
//   WIDTH=16/LANES=3 instance share one clock with separate resets.
// ---------------------------------------------------------------------------
module tb_mux_rr_lanes;
    logic clk;
    logic rst4_n;
    logic rst3_n;
    int   checks;
    int   failures;

    mux_rr_lanes_if #(.WIDTH(8),  .LANES(4)) bus4 ();
    mux_rr_lanes_if #(.WIDTH(16), .LANES(3)) bus3 ();

    mux_rr_lanes #(.WIDTH(8),  .LANES(4)) u4 (.clk_nf(clk), .reset_L(rst4_n), .bus(bus4));
    mux_rr_lanes #(.WIDTH(16), .LANES(3)) u3 (.clk_nf(clk), .reset_L(rst3_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot4(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] l, input logic fs, input bit chk_fs);
        chk({tag, " valid"}, {31'd0, bus4.valid_out}, {31'd0, v});
        chk({tag, " data"},  {24'd0, bus4.data_out},  {24'd0, d});
        chk({tag, " lane"},  {30'd0, bus4.lane_out},  {30'd0, l});
        if (chk_fs) chk({tag, " fs"}, {31'd0, bus4.frame_start}, {31'd0, fs});
    endtask

    task automatic slot3(input string tag, input logic v, input logic [15:0] d,
                         input logic [1:0] l, input logic fs);
        chk({tag, " valid"}, {31'd0, bus3.valid_out}, {31'd0, v});
        chk({tag, " data"},  {16'd0, bus3.data_out},  {16'd0, d});
        chk({tag, " lane"},  {30'd0, bus3.lane_out},  {30'd0, l});
        chk({tag, " fs"},    {31'd0, bus3.frame_start}, {31'd0, fs});
        chk({tag, " lane3"}, {31'd0, (bus3.lane_out == 2'd3)}, 32'd0);
    endtask

    task automatic zero4(input string tag);
        chk({tag, " valid"}, {31'd0, bus4.valid_out}, 32'd0);
        chk({tag, " data"},  {24'd0, bus4.data_out},  32'd0);
        chk({tag, " lane"},  {30'd0, bus4.lane_out},  32'd0);
        chk({tag, " fs"},    {31'd0, bus4.frame_start}, 32'd0);
    endtask

    logic [15:0] exp3 [3];

    initial begin
        checks   = 0;
        failures = 0;
        exp3[0]  = 16'h1111;
        exp3[1]  = 16'h2222;
        exp3[2]  = 16'h3333;

        rst4_n = 1'b0;
        rst3_n = 1'b0;
        bus4.data_in  = 32'hDDCC_BBAA;
        bus4.valid_in = 4'hF;
        bus4.lane_en  = 4'hF;
        bus4.align    = 1'b0;
        bus3.data_in  = 48'h3333_2222_1111;
        bus3.valid_in = 3'b111;
        bus3.lane_en  = 3'b111;
        bus3.align    = 1'b0;

        // Reset state
        #2;
        zero4("reset");
        step();
        rst4_n = 1'b1;

        // Empty reset slots, then the first frame
        for (int e = 1; e <= 4; e++) begin
            step();
            slot4($sformatf("idle E%0d", e), 1'b0, 8'h00, 2'(e - 1), 1'b0, e != 1);
        end
        step(); slot4("E5", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        step(); slot4("E6", 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1);
        step(); slot4("E7", 1'b1, 8'hCC, 2'd2, 1'b0, 1'b1);
        step(); slot4("E8", 1'b1, 8'hDD, 2'd3, 1'b0, 1'b1);

        // Masking: lane 2 disabled from the load at E12 on
        bus4.lane_en = 4'b1011;
        step(); slot4("E9",  1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        step(); slot4("E10", 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1);
        step(); slot4("E11", 1'b1, 8'hCC, 2'd2, 1'b0, 1'b1);
        step(); slot4("E12", 1'b1, 8'hDD, 2'd3, 1'b0, 1'b1);
        step(); slot4("mask E13", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        step(); slot4("mask E14", 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1);
        step(); slot4("mask E15", 1'b0, 8'hBB, 2'd2, 1'b0, 1'b1);
        step(); slot4("mask E16", 1'b1, 8'hDD, 2'd3, 1'b0, 1'b1);

        // Mid-frame changes after the E16 load must not touch this frame
        bus4.data_in  = 32'hDDCC_55AA;
        bus4.valid_in = 4'b1101;
        bus4.lane_en  = 4'hF;
        step(); slot4("mid E17", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        bus4.valid_in = 4'hF;
        step(); slot4("mid E18", 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1);
        step(); slot4("mid E19", 1'b0, 8'hBB, 2'd2, 1'b0, 1'b1);
        step(); slot4("mid E20", 1'b1, 8'hDD, 2'd3, 1'b0, 1'b1);
        step(); slot4("new E21", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        step(); slot4("new E22", 1'b1, 8'h55, 2'd1, 1'b0, 1'b1);
        step(); slot4("new E23", 1'b1, 8'hCC, 2'd2, 1'b0, 1'b1);
        step(); slot4("new E24", 1'b1, 8'hDD, 2'd3, 1'b0, 1'b1);
        step(); slot4("E25", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        step(); slot4("E26", 1'b1, 8'h55, 2'd1, 1'b0, 1'b1);

        // align pulse while lane_out == 1
        bus4.align   = 1'b1;
        bus4.data_in = 32'h4433_2211;
        step(); slot4("align E27", 1'b0, 8'h55, 2'd0, 1'b0, 1'b1);
        bus4.align = 1'b0;
        step(); slot4("align E28", 1'b1, 8'h11, 2'd0, 1'b1, 1'b1);
        step(); slot4("align E29", 1'b1, 8'h22, 2'd1, 1'b0, 1'b1);
        step(); slot4("align E30", 1'b1, 8'h33, 2'd2, 1'b0, 1'b1);
        step(); slot4("align E31", 1'b1, 8'h44, 2'd3, 1'b0, 1'b1);
        step(); slot4("align E32", 1'b1, 8'h11, 2'd0, 1'b1, 1'b1);
        step(); slot4("E33", 1'b1, 8'h22, 2'd1, 1'b0, 1'b1);
        step(); slot4("E34", 1'b1, 8'h33, 2'd2, 1'b0, 1'b1);

        // Reset asserted during the lane 2 slot
        bus4.data_in = 32'hDDCC_BBAA;
        rst4_n = 1'b0;
        #2;
        zero4("midrst");
        step();
        zero4("midrst held");
        rst4_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            slot4($sformatf("rerun E%0d", e), 1'b0, 8'h00, 2'(e - 1), 1'b0, e != 1);
        end
        step(); slot4("rerun E5", 1'b1, 8'hAA, 2'd0, 1'b1, 1'b1);
        step(); slot4("rerun E6", 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1);

        // LANES=3, WIDTH=16 instance
        rst3_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            chk($sformatf("l3 idle E%0d valid", e), {31'd0, bus3.valid_out}, 32'd0);
            chk($sformatf("l3 idle E%0d lane", e),  {30'd0, bus3.lane_out}, 32'(e - 1));
        end
        for (int e = 4; e <= 9; e++) begin
            step();
            slot3($sformatf("l3 E%0d", e), 1'b1, exp3[(e - 4) % 3], 2'((e - 4) % 3), (e - 4) % 3 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
